vsram_copy_engine: RTL

- Initiator that drives the 2-read/2-write 48-bit x 512-entry vector SRAM to copy a block of words from a source region to a destination region.
- Uses both read ports and both write ports, so it moves 2 words per cycle through a 2-stage read-capture-write pipeline.
- Sits between the vector control unit (start/done handshake) and the SRAM; it is the only agent on the SRAM ports while busy.

---
 rtl/vsram_pkg.sv | 19 +
 rtl/vsram_copy_addrgen.sv | 87 ++++++++
 rtl/vsram_copy_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vsram_pkg.sv
// Shared definitions for the vector SRAM copy engine.
//   AW    : SRAM address width (addresses wrap modulo DEPTH)
//   DW    : SRAM word width
//   DEPTH : SRAM entries, equal to 2**AW
package vsram_pkg;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 48;
   localparam int unsigned DEPTH = 512;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE,
      REJECT
   } copyState_t;

endpackage

// File: rtl/vsram_copy_addrgen.sv
// Beat counter and SRAM address-pair generator for the copy engine.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   load                    : latch srcAddr/dstAddr/len for a new copy
//   issue                   : issue the next read beat (two words)
//   commit                  : present the write pair for the last issued read
//   srcAddr, dstAddr, len   : copy request
//   lastBeat_c              : the beat issued this cycle is the final one
//   readDup                 : current read pair is an odd-tail duplicate
//   readAddress1/2          : registered SRAM read addresses
//   writeAddress1/2         : registered SRAM write addresses
module vsram_copy_addrgen
   import vsram_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load,
   input  logic          issue,
   input  logic          commit,
   input  logic [AW-1:0] srcAddr,
   input  logic [AW-1:0] dstAddr,
   input  logic [AW:0]   len,
   output logic          lastBeat_c,
   output logic          readDup,
   output logic [AW-1:0] readAddress1,
   output logic [AW-1:0] readAddress2,
   output logic [AW-1:0] writeAddress1,
   output logic [AW-1:0] writeAddress2
);

   localparam int unsigned LW = AW + 1;

   logic [AW-1:0] srcBase;
   logic [AW-1:0] dstBase;
   logic [AW-1:0] rdOffset;
   logic [AW-1:0] beatsLeft;
   logic          oddLen;
   logic          tailBeat;
   logic [AW-1:0] delta;
   logic [AW-1:0] nextRead1;
   logic [AW-1:0] nextRead2;

   // Next read pair; an odd-length tail reads the same word on both ports.
   always_comb begin
      lastBeat_c = (beatsLeft == AW'(1));
      tailBeat   = lastBeat_c & oddLen;
      delta      = dstBase - srcBase;
      nextRead1  = srcBase + rdOffset;
      nextRead2  = tailBeat ? nextRead1 : nextRead1 + AW'(1);
   end

   // Writes reuse the read pair shifted by the modular src->dst distance.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         srcBase       <= '0;
         dstBase       <= '0;
         rdOffset      <= '0;
         beatsLeft     <= '0;
         oddLen        <= 1'b0;
         readDup       <= 1'b0;
         readAddress1  <= '0;
         readAddress2  <= '0;
         writeAddress1 <= '0;
         writeAddress2 <= '0;
      end else begin
         if (load) begin
            srcBase   <= srcAddr;
            dstBase   <= dstAddr;
            rdOffset  <= '0;
            beatsLeft <= AW'((len + LW'(1)) >> 1);
            oddLen    <= len[0];
         end
         if (issue) begin
            readAddress1 <= nextRead1;
            readAddress2 <= nextRead2;
            readDup      <= tailBeat;
            rdOffset     <= rdOffset + AW'(2);
            beatsLeft    <= beatsLeft - AW'(1);
         end
         if (commit) begin
            writeAddress1 <= readAddress1 + delta;
            writeAddress2 <= readAddress2 + delta;
         end
      end
   end

endmodule

// File: rtl/vsram_copy_engine.sv
// Block copy initiator for the 2R/2W vector SRAM, two words per cycle.
// Ports:
//   clock, reset_n            : clock, synchronous active-low reset
//   start, src_addr, dst_addr, len : copy request (sampled in IDLE)
//   busy, done, err           : status; err qualifies the done pulse
//   WE                        : shared write enable for both write ports
//   ReadAddress1/2            : SRAM read addresses
//   WriteAddress1/2, WriteBus1/2 : SRAM write addresses and data
//   ReadBus1/2                : SRAM read data
module vsram_copy_engine
   import vsram_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          WE,
   output logic [AW-1:0] ReadAddress1,
   output logic [AW-1:0] ReadAddress2,
   output logic [AW-1:0] WriteAddress1,
   output logic [AW-1:0] WriteAddress2,
   output logic [DW-1:0] WriteBus1,
   output logic [DW-1:0] WriteBus2,
   input  logic [DW-1:0] ReadBus1,
   input  logic [DW-1:0] ReadBus2
);

   localparam int unsigned LW = AW + 1;

   copyState_t    state;
   copyState_t    stateNext;
   logic          busyNext;
   logic          doneNext;
   logic          errNext;
   logic          load;
   logic          issue;
   logic          rdValid;
   logic          lastBeat_c;
   logic          readDup;
   logic          reject_c;
   logic [AW-1:0] dist_c;

   vsram_copy_addrgen addrgen (
      .clock         (clock),
      .reset_n       (reset_n),
      .load          (load),
      .issue         (issue),
      .commit        (rdValid),
      .srcAddr       (src_addr),
      .dstAddr       (dst_addr),
      .len           (len),
      .lastBeat_c    (lastBeat_c),
      .readDup       (readDup),
      .readAddress1  (ReadAddress1),
      .readAddress2  (ReadAddress2),
      .writeAddress1 (WriteAddress1),
      .writeAddress2 (WriteAddress2)
   );

   // Forward copy is unsafe when the destination starts inside the source run.
   always_comb begin
      dist_c   = dst_addr - src_addr;
      reject_c = (len > LW'(DEPTH)) ||
                 ((dist_c != '0) && (LW'(dist_c) < len));
   end

   // Next-state and registered-output decode.
   always_comb begin
      stateNext = state;
      busyNext  = 1'b0;
      doneNext  = 1'b0;
      errNext   = 1'b0;
      load      = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               if (reject_c)          stateNext = REJECT;
               else if (len == '0)    stateNext = DONE;
               else                   stateNext = RUN;
            end
         end
         RUN: begin
            issue    = 1'b1;
            busyNext = 1'b1;
            if (lastBeat_c) stateNext = DRAIN;
         end
         DRAIN: begin
            busyNext  = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            doneNext  = 1'b1;
            stateNext = IDLE;
         end
         REJECT: begin
            doneNext  = 1'b1;
            errNext   = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State, status and write-enable registers; WE trails each read by one cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         WE      <= 1'b0;
         rdValid <= 1'b0;
      end else begin
         state   <= stateNext;
         busy    <= busyNext;
         done    <= doneNext;
         err     <= errNext;
         WE      <= rdValid;
         rdValid <= issue;
      end
   end

   // Read-data capture; the odd tail mirrors port 1 onto port 2.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         WriteBus1 <= '0;
         WriteBus2 <= '0;
      end else if (rdValid) begin
         WriteBus1 <= ReadBus1;
         WriteBus2 <= readDup ? ReadBus1 : ReadBus2;
      end
   end

endmodule
